serial_rf_receiver: RTL and testbench

Parametrised serial-link receiver that deframes packets from the one-bit `link` and drives a register-file write port directly. It is the next generation of the fixed 2-bit-address / 4-bit-data link receiver. It adds configurable address and data widths, an optional parity bit with error detection and counting, a receive enable, and zero-gap back-to-back packet reception. It sits between the serial link and a register file of 2**ADDR_W entries, each DATA_W bits wide.

---
 rtl/serial_rf_receiver_if.sv | 42 ++++
 rtl/serial_rf_receiver.sv | 145 ++++++++++++++
 tb/tb_serial_rf_receiver.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_rf_receiver_if.sv
// -----------------------------------------------------------------------------
// serial_rf_receiver_if
// Bundles the serial link input, the receive enable, and the register-file
// write port with its status outputs for serial_rf_receiver.
//   master : link source / register-file side (drives link, en; observes rest)
//   slave  : the receiver itself (samples link, en; drives write port/status)
// Signals:
//   link      serial input bit
//   en        receive enable, gates only the start of a packet
//   waddr     register-file write address
//   wdata     register-file write data
//   write     one-cycle write strobe
//   perr      one-cycle parity-error pulse
//   busy      packet reception in progress
//   err_count saturating parity-error count
//   pkt_count wrapping good-packet count
// -----------------------------------------------------------------------------
interface serial_rf_receiver_if #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
);
   logic              link;
   logic              en;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              write;
   logic              perr;
   logic              busy;
   logic [CNT_W-1:0]  err_count;
   logic [CNT_W-1:0]  pkt_count;

   modport master (
      output link, en,
      input  waddr, wdata, write, perr, busy, err_count, pkt_count
   );

   modport slave (
      input  link, en,
      output waddr, wdata, write, perr, busy, err_count, pkt_count
   );
endinterface

// File: rtl/serial_rf_receiver.sv
// -----------------------------------------------------------------------------
// serial_rf_receiver
// Deframes packets from a one-bit serial link and drives a register-file write
// port. Packet: start bit (1), address MSB first, data MSB first, then an
// optional parity bit. Good packets produce a one-cycle write strobe with the
// address/data; bad-parity packets produce a one-cycle perr pulse instead.
// A new packet may start on the edge right after the last payload bit.
// Ports:
//   clock : system clock, rising edge
//   clear : asynchronous active-high reset
//   bus   : serial_rf_receiver_if.slave (link, en in; write port/status out)
// Parameters:
//   ADDR_W      address width (1..8)
//   DATA_W      data width (1..32)
//   PARITY_MODE 0 none, 1 even, 2 odd; any other value behaves as none
//   CNT_W       width of the error and packet counters
// -----------------------------------------------------------------------------
module serial_rf_receiver #(
   parameter int ADDR_W      = 2,
   parameter int DATA_W      = 4,
   parameter int PARITY_MODE = 1,
   parameter int CNT_W       = 8
) (
   input logic                  clock,
   input logic                  clear,
   serial_rf_receiver_if.slave  bus
);

   localparam bit HAS_PAR = (PARITY_MODE == 1) || (PARITY_MODE == 2);
   localparam int N       = ADDR_W + DATA_W + (HAS_PAR ? 1 : 0);
   localparam int BW      = $clog2(N + 1);
   localparam logic [BW-1:0]    LAST_BIT = BW'(N - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   state_t            state_r;
   logic [BW-1:0]     bitcnt_r;
   logic [N-1:0]      shift_r;
   logic [ADDR_W-1:0] waddr_r;
   logic [DATA_W-1:0] wdata_r;
   logic              write_r;
   logic              perr_r;
   logic              busy_r;
   logic [CNT_W-1:0]  err_count_r;
   logic [CNT_W-1:0]  pkt_count_r;

   // The completion edge must judge the packet including the bit sampled at
   // that same edge, so the decode works on the would-be shifted word.
   logic [N-1:0]      word_s;
   logic [ADDR_W-1:0] addr_s;
   logic [DATA_W-1:0] data_s;
   logic              par_ok_s;

   // Parity check over address, data and parity bit; always OK without parity.
   function automatic logic parity_ok(input logic [N-1:0] w);
      logic ok;
      if (!HAS_PAR) begin
         ok = 1'b1;
      end else if (PARITY_MODE == 2) begin
         ok = ((^w) == 1'b1);
      end else begin
         ok = ((^w) == 1'b0);
      end
      return ok;
   endfunction

   assign word_s   = {shift_r[N-2:0], bus.link};
   assign addr_s   = word_s[N-1 -: ADDR_W];
   assign data_s   = word_s[N-1-ADDR_W -: DATA_W];
   assign par_ok_s = parity_ok(word_s);

   // Receive FSM, shift register, write port and counters.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_r     <= IDLE;
         bitcnt_r    <= {BW{1'b0}};
         shift_r     <= {N{1'b0}};
         waddr_r     <= {ADDR_W{1'b0}};
         wdata_r     <= {DATA_W{1'b0}};
         write_r     <= 1'b0;
         perr_r      <= 1'b0;
         busy_r      <= 1'b0;
         err_count_r <= {CNT_W{1'b0}};
         pkt_count_r <= {CNT_W{1'b0}};
      end else begin
         // Strobes are single-cycle unless re-asserted below.
         write_r <= 1'b0;
         perr_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.en && bus.link) begin
                  state_r  <= RECV;
                  bitcnt_r <= {BW{1'b0}};
                  busy_r   <= 1'b1;
               end else begin
                  state_r  <= IDLE;
                  busy_r   <= 1'b0;
               end
            end
            RECV: begin
               // en is deliberately ignored here: a started packet always finishes.
               shift_r <= word_s;
               if (bitcnt_r == LAST_BIT) begin
                  state_r  <= IDLE;
                  bitcnt_r <= {BW{1'b0}};
                  busy_r   <= 1'b0;
                  if (par_ok_s) begin
                     write_r     <= 1'b1;
                     waddr_r     <= addr_s;
                     wdata_r     <= data_s;
                     pkt_count_r <= pkt_count_r + CNT_W'(1);
                  end else begin
                     perr_r <= 1'b1;
                     if (err_count_r != CNT_MAX) begin
                        err_count_r <= err_count_r + CNT_W'(1);
                     end else begin
                        err_count_r <= err_count_r;
                     end
                  end
               end else begin
                  bitcnt_r <= bitcnt_r + BW'(1);
               end
            end
            default: begin
               state_r  <= IDLE;
               bitcnt_r <= {BW{1'b0}};
               busy_r   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.waddr     = waddr_r;
   assign bus.wdata     = wdata_r;
   assign bus.write     = write_r;
   assign bus.perr      = perr_r;
   assign bus.busy      = busy_r;
   assign bus.err_count = err_count_r;
   assign bus.pkt_count = pkt_count_r;

endmodule

// File: tb/tb_serial_rf_receiver.sv
// -----------------------------------------------------------------------------
// tb_serial_rf_receiver
// Drives two receivers: dut0 with defaults (2-bit addr, 4-bit data, even
// parity) and dut1 with 4-bit addr, 16-bit data, odd parity. Expected results
// come from a packet-level model: parity is judged by counting ones, good
// packets update the expected write port and wrap the packet count, bad ones
// bump a saturating error count.
// -----------------------------------------------------------------------------
module tb_serial_rf_receiver;

   logic clock = 1'b0;
   logic clear;
   int   cycle = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   // Packet-level model state per DUT.
   logic [7:0]  m_waddr [2];
   logic [31:0] m_wdata [2];
   int          m_err   [2];
   int          m_pkt   [2];
   int          last_wr_cycle;

   serial_rf_receiver_if #(.ADDR_W(2), .DATA_W(4),  .CNT_W(8)) bus0 ();
   serial_rf_receiver_if #(.ADDR_W(4), .DATA_W(16), .CNT_W(8)) bus1 ();

   serial_rf_receiver #(.ADDR_W(2), .DATA_W(4), .PARITY_MODE(1), .CNT_W(8)) dut0 (
      .clock (clock),
      .clear (clear),
      .bus   (bus0)
   );

   serial_rf_receiver #(.ADDR_W(4), .DATA_W(16), .PARITY_MODE(2), .CNT_W(8)) dut1 (
      .clock (clock),
      .clear (clear),
      .bus   (bus1)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cycle <= cycle + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_link(input int w, input logic b);
      if (w == 0) bus0.link = b; else bus1.link = b;
   endtask

   task automatic set_en(input int w, input logic b);
      if (w == 0) bus0.en = b; else bus1.en = b;
   endtask

   function automatic logic o_write(input int w); return (w == 0) ? bus0.write : bus1.write; endfunction
   function automatic logic o_perr(input int w);  return (w == 0) ? bus0.perr  : bus1.perr;  endfunction
   function automatic logic o_busy(input int w);  return (w == 0) ? bus0.busy  : bus1.busy;  endfunction
   function automatic logic [7:0] o_waddr(input int w);
      return (w == 0) ? 8'(bus0.waddr) : 8'(bus1.waddr);
   endfunction
   function automatic logic [31:0] o_wdata(input int w);
      return (w == 0) ? 32'(bus0.wdata) : 32'(bus1.wdata);
   endfunction
   function automatic logic [7:0] o_err(input int w); return (w == 0) ? bus0.err_count : bus1.err_count; endfunction
   function automatic logic [7:0] o_pkt(input int w); return (w == 0) ? bus0.pkt_count : bus1.pkt_count; endfunction

   // Parity bit that makes the packet good for the DUT's mode (dut1 is odd).
   function automatic logic good_bit(input int w, input logic [7:0] a, input logic [31:0] d);
      int ones;
      ones = $countones(a) + $countones(d);
      return (w == 0) ? logic'(ones % 2) : logic'(1 - (ones % 2));
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         m_waddr[k] = 8'd0;
         m_wdata[k] = 32'd0;
         m_err[k]   = 0;
         m_pkt[k]   = 0;
      end
   endfunction

   // Sends one packet with zero leading gap and checks every edge of it.
   task automatic send_packet(input int w, input logic [7:0] a_in, input logic [31:0] d_in,
                              input logic p, input bit drop_en);
      int          aw, dw, n;
      bit          good;
      logic [7:0]  a;
      logic [31:0] d;
      logic        bits[$];
      aw = (w == 0) ? 2 : 4;
      dw = (w == 0) ? 4 : 16;
      n  = aw + dw + 1;
      a  = a_in & 8'((1 << aw) - 1);
      d  = d_in & 32'((64'd1 << dw) - 64'd1);
      bits.push_back(1'b1);
      for (int i = aw - 1; i >= 0; i--) bits.push_back(a[i]);
      for (int i = dw - 1; i >= 0; i--) bits.push_back(d[i]);
      bits.push_back(p);
      good = ((($countones(a) + $countones(d) + int'(p)) % 2) == ((w == 0) ? 0 : 1));
      for (int i = 0; i <= n; i++) begin
         set_link(w, bits[i]);
         if (drop_en && i == 3) set_en(w, 1'b0);
         tick();
         if (i < n) begin
            n_checks++;
            if ({o_busy(w), o_write(w), o_perr(w)} !== 3'b100) begin
               n_fail++;
               $display("FAIL in_packet dut%0d bit %0d: busy/write/perr=%b expected 100",
                        w, i, {o_busy(w), o_write(w), o_perr(w)});
            end
         end
      end
      if (good) begin
         m_waddr[w] = a;
         m_wdata[w] = d;
         m_pkt[w]   = (m_pkt[w] + 1) % 256;
      end else begin
         m_err[w] = (m_err[w] < 255) ? m_err[w] + 1 : 255;
      end
      n_checks++;
      if ({o_busy(w), o_write(w), o_perr(w)} !== {1'b0, good, !good}) begin
         n_fail++;
         $display("FAIL completion_strobes dut%0d: busy/write/perr=%b expected %b",
                  w, {o_busy(w), o_write(w), o_perr(w)}, {1'b0, good, !good});
      end
      n_checks++;
      if (o_waddr(w) !== m_waddr[w]) begin
         n_fail++;
         $display("FAIL waddr dut%0d: got %0h expected %0h", w, o_waddr(w), m_waddr[w]);
      end
      n_checks++;
      if (o_wdata(w) !== m_wdata[w]) begin
         n_fail++;
         $display("FAIL wdata dut%0d: got %0h expected %0h", w, o_wdata(w), m_wdata[w]);
      end
      n_checks++;
      if (o_err(w) !== 8'(m_err[w])) begin
         n_fail++;
         $display("FAIL err_count dut%0d: got %0d expected %0d", w, o_err(w), m_err[w]);
      end
      n_checks++;
      if (o_pkt(w) !== 8'(m_pkt[w])) begin
         n_fail++;
         $display("FAIL pkt_count dut%0d: got %0d expected %0d", w, o_pkt(w), m_pkt[w]);
      end
      if (good) last_wr_cycle = cycle;
      set_link(w, 1'b0);
      set_en(w, 1'b1);
   endtask

   task automatic idle(input int w, input int k);
      set_link(w, 1'b0);
      for (int i = 0; i < k; i++) begin
         tick();
         n_checks++;
         if ({o_busy(w), o_write(w), o_perr(w)} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle dut%0d cycle %0d: busy/write/perr=%b expected 000",
                     w, i, {o_busy(w), o_write(w), o_perr(w)});
         end
      end
   endtask

   task automatic test_reset();
      clear = 1'b1;
      bus0.link = 1'b0; bus0.en = 1'b0;
      bus1.link = 1'b0; bus1.en = 1'b0;
      model_reset();
      tick();
      tick();
      for (int w = 0; w < 2; w++) begin
         n_checks++;
         if ({o_busy(w), o_write(w), o_perr(w), o_waddr(w), o_wdata(w), o_err(w), o_pkt(w)} !== 59'd0) begin
            n_fail++;
            $display("FAIL reset dut%0d: busy=%b write=%b perr=%b waddr=%0h wdata=%0h err=%0d pkt=%0d expected all 0",
                     w, o_busy(w), o_write(w), o_perr(w), o_waddr(w), o_wdata(w), o_err(w), o_pkt(w));
         end
      end
      #3 clear = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      bus0.en = 1'b1;
      send_packet(0, 8'h2, 32'h6, 1'b1, 1'b0);
      n_checks++;
      if ({o_waddr(0), o_wdata(0)} !== {8'd2, 32'd6}) begin
         n_fail++;
         $display("FAIL basic_values: waddr=%0h wdata=%0h expected 2/6", o_waddr(0), o_wdata(0));
      end
      idle(0, 2);
   endtask

   task automatic test_parity_error();
      logic [7:0]  a;
      logic [31:0] d;
      send_packet(0, 8'h2, 32'h6, 1'b0, 1'b0);
      idle(0, 1);
      for (int i = 0; i < 300; i++) begin
         a = 8'($urandom_range(3, 0));
         d = 32'($urandom_range(15, 0));
         send_packet(0, a, d, ~good_bit(0, a, d), 1'b0);
      end
      idle(0, 1);
      n_checks++;
      if (o_err(0) !== 8'd255) begin
         n_fail++;
         $display("FAIL err_saturate: got %0d expected 255", o_err(0));
      end
   endtask

   task automatic test_random();
      logic [7:0]  a;
      logic [31:0] d;
      logic        p;
      for (int i = 0; i < 150; i++) begin
         a = 8'($urandom_range(3, 0));
         d = 32'($urandom_range(15, 0));
         p = ($urandom_range(3, 0) == 0) ? ~good_bit(0, a, d) : good_bit(0, a, d);
         send_packet(0, a, d, p, ($urandom_range(3, 0) == 0));
         idle(0, $urandom_range(2, 0));
      end
   endtask

   task automatic test_back_to_back();
      int first_wr;
      idle(0, 1);
      send_packet(0, 8'h0, 32'hF, good_bit(0, 8'h0, 32'hF), 1'b0);
      first_wr = last_wr_cycle;
      send_packet(0, 8'h3, 32'h1, good_bit(0, 8'h3, 32'h1), 1'b0);
      n_checks++;
      if (last_wr_cycle - first_wr !== 8) begin
         n_fail++;
         $display("FAIL b2b_spacing: write pulses %0d cycles apart expected 8", last_wr_cycle - first_wr);
      end
      idle(0, 1);
   endtask

   task automatic test_enable();
      bus0.en = 1'b0;
      bus0.link = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         n_checks++;
         if ({o_busy(0), o_write(0)} !== 2'b00) begin
            n_fail++;
            $display("FAIL en_low cycle %0d: busy/write=%b expected 00", i, {o_busy(0), o_write(0)});
         end
      end
      bus0.en = 1'b1;
      idle(0, 1);
      send_packet(0, 8'h1, 32'h9, good_bit(0, 8'h1, 32'h9), 1'b1);
      n_checks++;
      if ({o_waddr(0), o_wdata(0)} !== {8'd1, 32'd9}) begin
         n_fail++;
         $display("FAIL en_drop_write: waddr=%0h wdata=%0h expected 1/9", o_waddr(0), o_wdata(0));
      end
      idle(0, 1);
   endtask

   task automatic test_async_clear();
      bus0.en = 1'b1;
      bus0.link = 1'b1;
      tick();
      bus0.link = 1'b1; tick();
      bus0.link = 1'b0; tick();
      bus0.link = 1'b1; tick();
      #2 clear = 1'b1;
      #1;
      model_reset();
      for (int w = 0; w < 2; w++) begin
         n_checks++;
         if ({o_busy(w), o_write(w), o_perr(w), o_waddr(w), o_wdata(w), o_err(w), o_pkt(w)} !== 59'd0) begin
            n_fail++;
            $display("FAIL async_clear dut%0d: busy=%b write=%b perr=%b waddr=%0h wdata=%0h err=%0d pkt=%0d expected all 0",
                     w, o_busy(w), o_write(w), o_perr(w), o_waddr(w), o_wdata(w), o_err(w), o_pkt(w));
         end
      end
      bus0.link = 1'b0;
      #2 clear = 1'b0;
      idle(0, 15);
      n_checks++;
      if (o_pkt(0) !== 8'd0) begin
         n_fail++;
         $display("FAIL after_clear_pkt: got %0d expected 0", o_pkt(0));
      end
      send_packet(0, 8'h3, 32'hA, good_bit(0, 8'h3, 32'hA), 1'b0);
      idle(0, 1);
   endtask

   task automatic test_wide();
      logic [7:0]  a;
      logic [31:0] d;
      int          start_cycle;
      bus1.en = 1'b1;
      idle(1, 1);
      start_cycle = cycle + 1;
      send_packet(1, 8'hA, 32'h8001, 1'b1, 1'b0);
      n_checks++;
      if (last_wr_cycle - start_cycle !== 21) begin
         n_fail++;
         $display("FAIL wide_latency: write %0d edges after start expected 21", last_wr_cycle - start_cycle);
      end
      n_checks++;
      if ({o_waddr(1), o_wdata(1)} !== {8'd10, 32'h8001}) begin
         n_fail++;
         $display("FAIL wide_values: waddr=%0h wdata=%0h expected a/8001", o_waddr(1), o_wdata(1));
      end
      send_packet(1, 8'h5, 32'h1234, ~good_bit(1, 8'h5, 32'h1234), 1'b0);
      for (int i = 0; i < 255; i++) begin
         a = 8'($urandom_range(15, 0));
         d = 32'($urandom_range(65535, 0));
         send_packet(1, a, d, good_bit(1, a, d), 1'b0);
      end
      idle(1, 1);
      n_checks++;
      if (o_pkt(1) !== 8'd0) begin
         n_fail++;
         $display("FAIL pkt_wrap: got %0d expected 0", o_pkt(1));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity_error();
      test_random();
      test_back_to_back();
      test_enable();
      test_async_clear();
      test_wide();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
